// File: rtl/dmem_access_unit_if.sv
// rtl/dmem_access_unit_if.sv - request/response and data-memory signal bundle for dmem_access_unit
interface dmem_access_unit_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    localparam int IDX_W = ADDR_W - 2;

    // Core request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // Core response channel
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;

    // Word-level data memory port
    logic [IDX_W-1:0]  mem_read_addr;
    logic [DATA_W-1:0] mem_read_data;
    logic [IDX_W-1:0]  mem_write_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_rw;

    // Core plus memory side
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_read_addr, mem_write_addr, mem_write_data, mem_rw
    );

    // Access unit side
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_read_addr, mem_write_addr, mem_write_data, mem_rw
    );
endinterface

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - byte-addressed load/store initiator for a 512-word data memory
module dmem_access_unit #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    dmem_access_unit_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD    = 3'd1;
    localparam logic [2:0] MERGE = 3'd2;
    localparam logic [2:0] WR    = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    logic [2:0]        state;
    logic              latWrite;
    logic [1:0]        latSize;
    logic              latUnsigned;
    logic [1:0]        latOff;
    logic [DATA_W-1:0] latWdata;

    logic              reqError;
    logic [7:0]        laneByte;
    logic [15:0]       laneHalf;
    logic [DATA_W-1:0] loadValue;
    logic [DATA_W-1:0] mergedWord;

    assign bus.req_ready = (state == IDLE);

    // Misaligned or illegal-size requests never touch memory
    always_comb begin
        reqError = 1'b0;
        case (bus.req_size)
            2'b01:   reqError = bus.req_addr[0];
            2'b10:   reqError = (bus.req_addr[1:0] != 2'b00);
            2'b11:   reqError = 1'b1;
            default: reqError = 1'b0;
        endcase
    end

    // Little-endian lane extraction with sign/zero extension, and store merge into the old word
    always_comb begin
        laneByte   = bus.mem_read_data[{latOff, 3'b000} +: 8];
        laneHalf   = bus.mem_read_data[{latOff[1], 4'b0000} +: 16];
        loadValue  = bus.mem_read_data;
        mergedWord = bus.mem_read_data;
        case (latSize)
            2'b00: begin
                loadValue = {{24{~latUnsigned & laneByte[7]}}, laneByte};
                mergedWord[{latOff, 3'b000} +: 8] = latWdata[7:0];
            end
            2'b01: begin
                loadValue = {{16{~latUnsigned & laneHalf[15]}}, laneHalf};
                mergedWord[{latOff[1], 4'b0000} +: 16] = latWdata[15:0];
            end
            default: begin
                loadValue  = bus.mem_read_data;
                mergedWord = latWdata;
            end
        endcase
    end

    // Sequencer: every memory-facing output is a flop so mem_rw never glitches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            latWrite           <= 1'b0;
            latSize            <= 2'b00;
            latUnsigned        <= 1'b0;
            latOff             <= 2'b00;
            latWdata           <= '0;
            bus.resp_valid     <= 1'b0;
            bus.resp_error     <= 1'b0;
            bus.resp_rdata     <= '0;
            bus.mem_rw         <= 1'b0;
            bus.mem_read_addr  <= '0;
            bus.mem_write_addr <= '0;
            bus.mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        latWrite    <= bus.req_write;
                        latSize     <= bus.req_size;
                        latUnsigned <= bus.req_unsigned;
                        latOff      <= bus.req_addr[1:0];
                        latWdata    <= bus.req_wdata;
                        if (reqError) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_error <= 1'b1;
                            bus.resp_rdata <= '0;
                            state          <= RESP;
                        end else if (bus.req_write && bus.req_size == 2'b10) begin
                            // Full-word store needs no old data: go straight to setup
                            bus.mem_write_addr <= bus.req_addr[ADDR_W-1:2];
                            bus.mem_write_data <= bus.req_wdata;
                            state              <= MERGE;
                        end else begin
                            bus.mem_read_addr <= bus.req_addr[ADDR_W-1:2];
                            state             <= RD;
                        end
                    end
                end
                RD: begin
                    if (latWrite) begin
                        bus.mem_write_addr <= bus.mem_read_addr;
                        bus.mem_write_data <= mergedWord;
                        state              <= MERGE;
                    end else begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_error <= 1'b0;
                        bus.resp_rdata <= loadValue;
                        state          <= RESP;
                    end
                end
                MERGE: begin
                    bus.mem_rw <= 1'b1;
                    state      <= WR;
                end
                WR: begin
                    bus.mem_rw     <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_error <= 1'b0;
                    bus.resp_rdata <= '0;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - scoreboard bench for dmem_access_unit with a 512-word memory model
module tb_dmem_access_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic initMem = 1'b1;

    dmem_access_unit_if bus ();

    dmem_access_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rw;
        logic [8:0]  waddr;
        logic [31:0] wdata;
    } expEntry_t;

    expEntry_t   expQ[$];
    logic [31:0] mem [512];
    logic [31:0] shadow [512];
    int          checks = 0;
    int          failures = 0;
    int          rwCount = 0;
    logic [8:0]  lastWaddr;
    logic [31:0] lastWdata;

    function automatic logic [31:0] memPattern(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // Memory model: combinational read, write on rising edge while mem_rw is high
    assign bus.mem_read_data = mem[bus.mem_read_addr];

    always @(posedge clk) begin
        if (initMem) begin
            for (int i = 0; i < 512; i++) mem[i] <= memPattern(i);
        end else if (bus.mem_rw) begin
            mem[bus.mem_write_addr] <= bus.mem_write_data;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_rw) begin
            rwCount   = rwCount + 1;
            lastWaddr = bus.mem_write_addr;
            lastWdata = bus.mem_write_data;
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int memMismatches(input int skip);
        int n = 0;
        for (int i = 0; i < 512; i++)
            if (i != skip && mem[i] !== shadow[i]) n++;
        return n;
    endfunction

    task automatic doReq(input logic w, input logic [1:0] sz, input logic uns, input logic [10:0] addr,
                         input logic [31:0] wd, input logic [31:0] expRdata, input logic expErr,
                         input int expLat, input int expRw, input logic [8:0] expWaddr,
                         input logic [31:0] expWdata, input int stall);
        expEntry_t e;
        int n;
        int lat;
        logic got;
        logic [31:0] held;
        e.rdata = expRdata; e.err = expErr; e.lat = expLat;
        e.rw = expRw; e.waddr = expWaddr; e.wdata = expWdata;
        expQ.push_back(e);
        @(negedge clk);
        rwCount = 0;
        bus.req_write = w; bus.req_size = sz; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkEq("acceptReady", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.resp_ready = (stall == 0);
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = i;
                got = 1'b1;
            end
        end
        e = expQ.pop_front();
        checkEq("respArrived", 32'(got), 32'd1);
        checkEq("latency", 32'(lat), 32'(e.lat));
        checkEq("rdata", bus.resp_rdata, e.rdata);
        checkEq("error", 32'(bus.resp_error), 32'(e.err));
        checkEq("reqReadyInResp", 32'(bus.req_ready), 32'd0);
        held = bus.resp_rdata;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkEq("stallValid", 32'(bus.resp_valid), 32'd1);
            checkEq("stallRdata", bus.resp_rdata, held);
            checkEq("stallReqReady", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkEq("idleReqReady", 32'(bus.req_ready), 32'd1);
        checkEq("idleRespValid", 32'(bus.resp_valid), 32'd0);
        checkEq("rwCycles", 32'(rwCount), 32'(e.rw));
        if (e.rw != 0) begin
            checkEq("writeAddr", 32'(lastWaddr), 32'(e.waddr));
            checkEq("writeData", lastWdata, e.wdata);
            shadow[e.waddr] = e.wdata;
        end
        checkEq("memImage", 32'(memMismatches(-1)), 32'd0);
    endtask

    initial begin
        int n;
        int respCnt;
        logic seen;
        for (int i = 0; i < 512; i++) shadow[i] = memPattern(i);
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.resp_ready = 1'b1;

        #2 reset_n = 1'b0;
        #1;
        checkEq("rstReqReady", 32'(bus.req_ready), 32'd1);
        checkEq("rstRespValid", 32'(bus.resp_valid), 32'd0);
        checkEq("rstRespError", 32'(bus.resp_error), 32'd0);
        checkEq("rstRespRdata", bus.resp_rdata, 32'd0);
        checkEq("rstMemRw", 32'(bus.mem_rw), 32'd0);
        checkEq("rstReadAddr", 32'(bus.mem_read_addr), 32'd0);
        checkEq("rstWriteAddr", 32'(bus.mem_write_addr), 32'd0);
        checkEq("rstWriteData", bus.mem_write_data, 32'd0);
        @(posedge clk);
        #1 initMem = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // w, size, uns, addr, wdata, expRdata, expErr, lat, rw, waddr, wdata, stall
        doReq(1, 2'b10, 0, 11'h010, 32'hDEADBEEF, 32'h0, 0, 3, 1, 9'd4, 32'hDEADBEEF, 0);
        doReq(0, 2'b10, 0, 11'h010, 32'h0, 32'hDEADBEEF, 0, 2, 0, 9'd0, 32'h0, 0);
        doReq(1, 2'b10, 0, 11'h010, 32'h11223344, 32'h0, 0, 3, 1, 9'd4, 32'h11223344, 0);
        doReq(1, 2'b00, 0, 11'h012, 32'hFFFFFFAA, 32'h0, 0, 4, 1, 9'd4, 32'h11AA3344, 0);
        doReq(0, 2'b10, 0, 11'h010, 32'h0, 32'h11AA3344, 0, 2, 0, 9'd0, 32'h0, 0);
        doReq(1, 2'b10, 0, 11'h014, 32'h8001F0FF, 32'h0, 0, 3, 1, 9'd5, 32'h8001F0FF, 0);
        doReq(0, 2'b01, 0, 11'h016, 32'h0, 32'hFFFF8001, 0, 2, 0, 9'd0, 32'h0, 0);
        doReq(0, 2'b01, 1, 11'h016, 32'h0, 32'h00008001, 0, 2, 0, 9'd0, 32'h0, 0);
        doReq(0, 2'b00, 0, 11'h014, 32'h0, 32'hFFFFFFFF, 0, 2, 0, 9'd0, 32'h0, 0);
        doReq(0, 2'b00, 1, 11'h015, 32'h0, 32'h000000F0, 0, 2, 0, 9'd0, 32'h0, 0);
        doReq(0, 2'b01, 0, 11'h014, 32'h0, 32'hFFFFF0FF, 0, 2, 0, 9'd0, 32'h0, 0);
        doReq(1, 2'b10, 0, 11'h018, 32'h12345678, 32'h0, 0, 3, 1, 9'd6, 32'h12345678, 0);
        doReq(1, 2'b01, 0, 11'h01A, 32'h0000BEEF, 32'h0, 0, 4, 1, 9'd6, 32'hBEEF5678, 0);
        doReq(0, 2'b10, 0, 11'h013, 32'h0, 32'h0, 1, 1, 0, 9'd0, 32'h0, 0);
        doReq(0, 2'b01, 0, 11'h015, 32'h0, 32'h0, 1, 1, 0, 9'd0, 32'h0, 0);
        doReq(1, 2'b11, 0, 11'h010, 32'h55555555, 32'h0, 1, 1, 0, 9'd0, 32'h0, 0);
        doReq(1, 2'b10, 0, 11'h7FC, 32'hCAFEF00D, 32'h0, 0, 3, 1, 9'd511, 32'hCAFEF00D, 0);
        doReq(1, 2'b00, 0, 11'h7FF, 32'h0000005A, 32'h0, 0, 4, 1, 9'd511, 32'h5AFEF00D, 0);
        doReq(0, 2'b00, 0, 11'h7FF, 32'h0, 32'h0000005A, 0, 2, 0, 9'd0, 32'h0, 0);
        doReq(0, 2'b10, 0, 11'h014, 32'h0, 32'h8001F0FF, 0, 2, 0, 9'd0, 32'h0, 5);

        // Reset asserted while a byte store to word 7 is in its write cycle
        @(negedge clk);
        bus.req_write = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = 11'h01D; bus.req_wdata = 32'h00000077; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            seen = bus.mem_rw;
            n++;
        end
        checkEq("rstSeenWrite", 32'(seen), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkEq("midRstMemRw", 32'(bus.mem_rw), 32'd0);
        checkEq("midRstReqReady", 32'(bus.req_ready), 32'd1);
        checkEq("midRstRespValid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        respCnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid) respCnt++;
        end
        checkEq("midRstNoResp", 32'(respCnt), 32'd0);
        checkEq("midRstOtherWords", 32'(memMismatches(7)), 32'd0);
        shadow[7] = mem[7];
        doReq(0, 2'b10, 0, 11'h020, 32'h0, memPattern(8), 0, 2, 0, 9'd0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
